// File: rtl/dcache_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dcache_frame                                               |
// | Description : One data-cache frame: a WORDS-word line with tag, valid,   |
// |               dirty and recently-used state, plus word-serial refill and |
// |               writeback sequencers, CPU store merge and invalidate.      |
// | Options     : DCACHE_FRAME_BYTE_WRITE_EN - store hits honour cpu_be      |
// |               (otherwise full-word stores, cpu_be ignored).              |
// | Ports       : CLK/nRST (async active-low reset)                          |
// |               rd_off/rd_data       - combinational word read            |
// |               tag_out/valid/dirty/ru/busy - line and sequencer state     |
// |               cpu_wen/off/wdata/be - store hit                           |
// |               ru_wen/ru_in         - RU update                           |
// |               fill_*               - refill request and word stream      |
// |               wb_*                 - writeback request and word stream   |
// |               inv                  - coherence invalidate                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dcache_frame #(
   parameter int         WORDS  = 2,
   parameter int         TAG_W  = 26,
   parameter logic       RU_RST = 1'b0,
   localparam int        OFF_W  = $clog2(WORDS)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [OFF_W-1:0] rd_off,
   output logic [31:0]      rd_data,
   output logic [TAG_W-1:0] tag_out,
   output logic             valid,
   output logic             dirty,
   output logic             ru,
   output logic             busy,
   input  logic             cpu_wen,
   input  logic [OFF_W-1:0] cpu_off,
   input  logic [31:0]      cpu_wdata,
   input  logic [3:0]       cpu_be,
   input  logic             ru_wen,
   input  logic             ru_in,
   input  logic             fill_start,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic             fill_valid,
   input  logic [31:0]      fill_data,
   output logic             fill_ready,
   output logic             fill_done,
   input  logic             wb_start,
   output logic             wb_valid,
   output logic [31:0]      wb_data,
   input  logic             wb_ready,
   output logic             wb_done,
   input  logic             inv
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   localparam logic [OFF_W-1:0] C_LAST = OFF_W'(WORDS - 1);
   localparam logic [OFF_W-1:0] C_ONE  = OFF_W'(1);

   state_t             state_q, state_d;
   logic [OFF_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic               dirty_q, dirty_d;
   logic               ru_q, ru_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [TAG_W-1:0]   ptag_q, ptag_d;
   logic               fill_done_q, fill_done_d;
   logic               wb_done_q, wb_done_d;
   logic [31:0]        data_q [WORDS];
   logic [31:0]        data_d [WORDS];

`ifndef DCACHE_FRAME_BYTE_WRITE_EN
   // Byte enables have no effect in full-word store builds.
   logic unused_be;
   assign unused_be = ^cpu_be;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      ru_d        = ru_q;
      tag_d       = tag_q;
      ptag_d      = ptag_q;
      fill_done_d = 1'b0;
      wb_done_d   = 1'b0;
      data_d      = data_q;

      // RU is independent of the sequencer, and is written even alongside inv.
      if (ru_wen) begin
         ru_d = ru_in;
      end

      if (inv) begin
         // Invalidate overrides everything; tag and data stay as they were.
         state_d = ST_IDLE;
         cnt_d   = '0;
         valid_d = 1'b0;
         dirty_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (wb_start) begin
                  // wb_start wins over fill_start; a clean line just acks.
                  if (valid_q && dirty_q) begin
                     state_d = ST_WB;
                     cnt_d   = '0;
                  end else begin
                     wb_done_d = 1'b1;
                  end
               end else if (fill_start) begin
                  state_d = ST_FILL;
                  cnt_d   = '0;
                  ptag_d  = fill_tag;
                  valid_d = 1'b0;
                  dirty_d = 1'b0;
               end else if (cpu_wen && valid_q) begin
`ifdef DCACHE_FRAME_BYTE_WRITE_EN
                  for (int b = 0; b < 4; b++) begin
                     if (cpu_be[b]) begin
                        data_d[cpu_off][8*b +: 8] = cpu_wdata[8*b +: 8];
                     end
                  end
                  dirty_d = dirty_q | (|cpu_be);
`else
                  data_d[cpu_off] = cpu_wdata;
                  dirty_d         = 1'b1;
`endif
               end
            end

            ST_FILL: begin
               if (fill_valid) begin
                  data_d[cnt_q] = fill_data;
                  if (cnt_q == C_LAST) begin
                     state_d     = ST_IDLE;
                     cnt_d       = '0;
                     tag_d       = ptag_q;
                     valid_d     = 1'b1;
                     dirty_d     = 1'b0;
                     fill_done_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + C_ONE;
                  end
               end
            end

            ST_WB: begin
               if (wb_ready) begin
                  if (cnt_q == C_LAST) begin
                     state_d   = ST_IDLE;
                     cnt_d     = '0;
                     dirty_d   = 1'b0;
                     wb_done_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + C_ONE;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         valid_q     <= 1'b0;
         dirty_q     <= 1'b0;
         ru_q        <= RU_RST;
         tag_q       <= '0;
         ptag_q      <= '0;
         fill_done_q <= 1'b0;
         wb_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         ru_q        <= ru_d;
         tag_q       <= tag_d;
         ptag_q      <= ptag_d;
         fill_done_q <= fill_done_d;
         wb_done_q   <= wb_done_d;
      end
   end

   // Line data carries no reset; it is meaningless until a refill lands.
   always_ff @(posedge CLK) begin
      data_q <= data_d;
   end

   assign rd_data    = data_q[rd_off];
   assign wb_data    = data_q[cnt_q];
   assign tag_out    = tag_q;
   assign valid      = valid_q;
   assign dirty      = dirty_q;
   assign ru         = ru_q;
   assign busy       = (state_q != ST_IDLE);
   assign fill_ready = (state_q == ST_FILL);
   assign wb_valid   = (state_q == ST_WB);
   assign fill_done  = fill_done_q;
   assign wb_done    = wb_done_q;

endmodule
`default_nettype wire
